seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller. It accepts a pattern configuration via a valid/ready handshake, arms on start, and scans a qualified serial bit stream. It counts hits in overlapping or non-overlapping mode and completes after a programmed hit target. It is the control/configuration wrapper the team uses in place of hard-coded fixed-pattern detectors.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of hit target and hit counter
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNT_W  hits until done; 0 = run until abort
start  in  1  begin scan (ARMED only)
abort  in  1  stop scan immediately
data_valid  in  1  qualifies data_in
data_in  in  1  serial data bit
hit  out  1  one-cycle pulse, registered
hit_count  out  CNT_W  hits since start, saturating
busy  out  1  high in RUN
done  out  1  high in DONE
timeout  out  1  one-cycle pulse (SEQ_DET_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset: state=IDLE; hit, hit_count, busy, done, timeout=0; shift history=0; fill=0; cfg registers=0.
- States: IDLE, ARMED, RUN, DONE.
- cfg_ready=1 in IDLE and DONE. A handshake latches pattern/len/overlap/target and goes to ARMED. Illegal cfg_len (0 or >MAX_LEN) is accepted but clamped to MAX_LEN.
- ARMED: start -> RUN, clears hit_count, history, and fill. A new cfg is not accepted in ARMED (cfg_ready=0).
- RUN: on data_valid, history <= {history, data_in}; fill increments, saturating at len. Match when (fill+1)>=len and the low len history bits, including the current bit, equal cfg_pattern[len-1:0]. hit asserts the cycle after the matching sample (latency 1). hit_count increments in the same cycle as hit and saturates at all-ones.
- Overlap=1: fill is kept on a hit. Overlap=0: fill is cleared on a hit, so the next match needs len fresh bits.
- Target reached: a hit that makes hit_count==cfg_target (target!=0) moves to DONE on the same edge as the hit pulse.
- Idle sampling: data_valid=0 holds all state. Bits outside RUN are ignored.
- abort: any state except IDLE -> DONE next edge; hit_count is held. Abort has priority over start, match, and cfg in the same cycle.
- DONE: done=1, hit_count is held. A new cfg handshake -> ARMED. start in DONE re-runs with the held config -> RUN.
- Reset mid-RUN: all outputs return to reset values asynchronously. The config is lost.

Optional Feature:
SEQ_DET_TIMEOUT_EN: adds parameter TIMEOUT_BITS (default 64) and a counter of valid bits since the last hit or start. When it reaches TIMEOUT_BITS in RUN, timeout pulses for 1 cycle and the state moves to DONE. Without the macro there is no counter, timeout is constant 0, and there is no timeout exit.

Decomposition:
- Package seq_det_pkg: state enum (IDLE, ARMED, RUN, DONE), default MAX_LEN/CNT_W constants, cfg struct typedef (pattern, len, overlap, target).
- Sub-module seq_match_core: history shift register, fill counter, masked compare. Inputs: shift enable, clear, len, pattern, overlap. Output: combinational match.
- The controller FSM, counter, and handshake live in seq_detect_ctrl.

Test Plan:
- Overlap hits: cfg pattern=8'b0001_0110, len=5, overlap=1, target=0; start; stream 1,0,1,1,0,1,1,0 every cycle -> hit pulses after bits 5 and 8; hit_count=2.
- Non-overlap: same cfg with overlap=0, same stream -> one hit after bit 5; hit_count=1.
- Target and gaps: same pattern, target=2, data_valid toggled 1/0; stream 10110 10110 -> done after the 2nd hit on the hit edge; cfg_ready=1; further bits ignored; count stays 2.
- Abort priority: abort together with the matching 5th bit -> no hit, DONE, hit_count=0. Then start -> RUN with a cleared count.
- Reset mid-RUN: assert rst asynchronously between clock edges after 3 hits -> outputs 0 immediately, state IDLE, cfg_ready=1.
- Timeout (SEQ_DET_TIMEOUT_EN, TIMEOUT_BITS=64): 64 valid zeros in RUN -> timeout pulse, done=1, hit_count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial-pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_MAX_LEN-1:0] pattern;
    logic [DEF_LEN_W-1:0]   len;
    logic                   overlap;
    logic [DEF_CNT_W-1:0]   target;
  } cfg_t;

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and length-masked pattern compare.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               data_in,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W:0]     fill_inc;
  logic               full;

  // The compare includes the bit being shifted in this cycle.
  always_comb begin
    cand = {history[MAX_LEN-2:0], data_in};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
    fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
    full     = (fill_inc >= {1'b0, len});
    match    = shift_en && full && ((cand & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= cand;
      if (match && !overlap) fill <= '0;
      else if (full)         fill <= len;
      else                   fill <= fill_inc[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial-pattern detection controller (handshake, FSM, hit counter).
// Optional macro SEQ_DET_TIMEOUT_EN adds a no-hit bit timeout (TIMEOUT_BITS).
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
`ifdef SEQ_DET_TIMEOUT_EN
  parameter int TIMEOUT_BITS = 64,
`endif
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_count,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ARMED = ARMED;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]         state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic               cfg_load;
  logic               start_run;
  logic               shift_en;
  logic               match;
  logic               to_hit;
  logic [CNT_W-1:0]   count_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0 || int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  // Abort wins over a cfg offered in DONE, so ready drops with it.
  assign cfg_ready  = (state == ST_IDLE) || (state == ST_DONE && !abort);
  assign cfg_load   = cfg_valid && cfg_ready;
  assign start_run  = start && !abort &&
                      (state == ST_ARMED || (state == ST_DONE && !cfg_load));
  assign shift_en   = (state == ST_RUN) && data_valid && !abort;
  assign count_next = sat_inc(hit_count);
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (start_run),
    .data_in  (data_in),
    .len      (len_q),
    .pattern  (pattern_q),
    .overlap  (overlap_q),
    .match    (match)
  );

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  assign to_hit  = shift_en && !match && (to_cnt == TO_W'(TIMEOUT_BITS - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (start_run)     to_cnt <= '0;
      else if (shift_en) to_cnt <= match ? '0 : to_cnt + TO_W'(1);
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hit       <= 1'b0;
      hit_count <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
    end else begin
      hit <= 1'b0;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        len_q     <= clamp_len(cfg_len);
        overlap_q <= cfg_overlap;
        target_q  <= cfg_target;
      end
      case (state)
        ST_IDLE: begin
          if (cfg_load) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (abort) begin
            state <= ST_DONE;
          end else if (start_run) begin
            state     <= ST_RUN;
            hit_count <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_DONE;
          end else if (match) begin
            hit       <= 1'b1;
            hit_count <= count_next;
            if (target_q != '0 && count_next == target_q) state <= ST_DONE;
          end else if (to_hit) begin
            state <= ST_DONE;
          end
        end
        default: begin
          if (cfg_load) begin
            state <= ST_ARMED;
          end else if (start_run) begin
            state     <= ST_RUN;
            hit_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: expected hit counts queued at stimulus, popped on hit.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [7:0] PAT = 8'b0001_0110;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               data_valid;
  logic               data_in;
  logic               hit;
  logic [CNT_W-1:0]   hit_count;
  logic               busy;
  logic               done;
  logic               timeout;

  int checks = 0;
  int errors = 0;
  int to_seen = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] mon_exp;

  seq_detect_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .hit         (hit),
    .hit_count   (hit_count),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every hit pulse must match the next queued expected count.
  always @(negedge clk) begin
    if (timeout === 1'b1) to_seen++;
    if (hit === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit: hit_count=%0d but no hit expected", hit_count);
      end else begin
        mon_exp = exp_q.pop_front();
        if (hit_count !== mon_exp) begin
          errors++;
          $display("FAIL hit_count_on_hit: got %0d expected %0d", hit_count, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [LEN_W-1:0] len,
                        input logic ov, input logic [CNT_W-1:0] tgt);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_target  = tgt;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send(input logic b, input bit exp_hit, input logic [CNT_W-1:0] exp_cnt);
    if (exp_hit) exp_q.push_back(exp_cnt);
    data_valid = 1'b1;
    data_in    = b;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
    start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = 1'b0;
    #2;
    chk("rst_hit", hit, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Overlapping detection: hits after bits 5 and 8
    do_cfg(PAT, 4'd5, 1'b1, 8'd0);
    chk("armed_cfg_ready", cfg_ready, 0);
    chk("armed_busy", busy, 0);
    do_start();
    chk("run_busy", busy, 1);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 1);
    send(1, 0, 0); send(1, 0, 0); send(0, 1, 2);
    tick();
    chk("ovl_count", hit_count, 2);
    chk("ovl_busy", busy, 1);
    do_abort();
    chk("ovl_abort_done", done, 1);
    chk("ovl_abort_held", hit_count, 2);

    // Non-overlapping: one hit
    do_cfg(PAT, 4'd5, 1'b0, 8'd0);
    do_start();
    chk("novl_cleared", hit_count, 0);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    tick();
    chk("novl_count", hit_count, 1);
    do_abort();

    // Target 2 with gapped valid
    do_cfg(PAT, 4'd5, 1'b0, 8'd2);
    do_start();
    begin
      logic [9:0] stream;
      stream = 10'b10110_10110;
      for (int i = 9; i >= 0; i--) begin
        send(stream[i], (i == 5 || i == 0), (i == 5) ? 8'd1 : 8'd2);
        if (i != 0) begin
          data_in = ~stream[i];
          tick();
        end
      end
    end
    chk("tgt_done_on_hit_edge", done, 1);
    chk("tgt_hit_pulse", hit, 1);
    chk("tgt_busy", busy, 0);
    chk("tgt_cfg_ready", cfg_ready, 1);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    chk("tgt_count_held", hit_count, 2);
    chk("tgt_still_done", done, 1);

    // Abort wins over a matching 5th bit
    do_cfg(PAT, 4'd5, 1'b1, 8'd0);
    do_start();
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    abort = 1'b1; data_valid = 1'b1; data_in = 1'b0;
    tick();
    abort = 1'b0; data_valid = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_no_hit", hit, 0);
    chk("abort_count", hit_count, 0);
    do_start();
    chk("restart_busy", busy, 1);
    chk("restart_count", hit_count, 0);

    // Three overlapping hits, then asynchronous reset mid-cycle
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 1);
    send(1, 0, 0); send(1, 0, 0); send(0, 1, 2);
    send(1, 0, 0); send(1, 0, 0); send(0, 1, 3);
    tick();
    chk("pre_rst_count", hit_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_hit_count", hit_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hit", hit, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    #2 rst = 1'b0;
    tick();
    do_start();
    chk("idle_start_ignored", busy, 0);

`ifdef SEQ_DET_TIMEOUT_EN
    // 64 zeros without a hit
    do_cfg(PAT, 4'd5, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 63; i++) send(0, 0, 0);
    chk("to_not_yet", timeout, 0);
    chk("to_still_busy", busy, 1);
    send(0, 0, 0);
    chk("to_pulse", timeout, 1);
    chk("to_done", done, 1);
    chk("to_count", hit_count, 0);
    tick();
    chk("to_pulse_end", timeout, 0);
`else
    chk("timeout_tied_low", to_seen, 0);
`endif

    tick();
    chk("pending_hits", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
